// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD counter and its display decoder.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [6:0] seg7_t;

   // Active-low segment pattern for a dark digit.
   localparam seg7_t SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0-9.
   localparam seg7_t SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Clamp an out-of-range digit to 9.
   function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Single-digit BCD to active-low seven-segment decoder; non-BCD codes blank the digit.
module bcd_to_7seg
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   output seg7_t      seg
);

   // Table lookup for valid digits, blank otherwise.
   always_comb begin
      seg = SEG_BLANK;
      if (digit <= 4'd9) begin
         seg = SEG_LUT[digit];
      end
   end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit up/down BCD counter with programmable modulo, load, terminal-count pulse
// and per-digit seven-segment outputs.
// Build option: define BCD_COUNTER_N_SEG_EN to instantiate the segment decoders;
// otherwise seg is tied high (display blank).
module bcd_counter_n
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic [4*DIGITS-1:0]   limit,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tc,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] bcd_q, bcd_d;
   logic         tc_q, tc_d;
   logic [W-1:0] load_s, lim_s;
   logic [W-1:0] bcd_inc, bcd_dec;
   logic         carry, borrow;
   bcd_digit_t   cur;

   // Per-digit input sanitising: bad load digits become 0, bad limit digits become 9.
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_t ld;
      assign ld                 = load_val[4*i +: 4];
      assign load_s[4*i +: 4]   = (ld > 4'd9) ? 4'd0 : ld;
      assign lim_s[4*i +: 4]    = bcd_sanitize(limit[4*i +: 4]);
   end

   // Ripple carry/borrow chain from digit 0 for the increment and decrement candidates.
   always_comb begin
      bcd_inc = bcd_q;
      bcd_dec = bcd_q;
      carry   = 1'b1;
      borrow  = 1'b1;
      cur     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         cur = bcd_q[4*i +: 4];
         if (carry) begin
            if (cur == 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = cur + 4'd1;
               carry             = 1'b0;
            end
         end
         if (borrow) begin
            if (cur == 4'd0) begin
               bcd_dec[4*i +: 4] = 4'd9;
            end else begin
               bcd_dec[4*i +: 4] = cur - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   // Next-state selection: load beats enable; wrap raises tc for one cycle.
   always_comb begin
      bcd_d = bcd_q;
      tc_d  = 1'b0;
      if (load) begin
         bcd_d = load_s;
      end else if (en) begin
         if (up) begin
            // >= also catches a limit lowered below the current count.
            if (bcd_q >= lim_s) begin
               bcd_d = '0;
               tc_d  = 1'b1;
            end else begin
               bcd_d = bcd_inc;
            end
         end else begin
            if (bcd_q == '0) begin
               bcd_d = lim_s;
               tc_d  = 1'b1;
            end else begin
               bcd_d = bcd_dec;
            end
         end
      end
   end

   // Count and terminal-count registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         bcd_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         bcd_q <= bcd_d;
         tc_q  <= tc_d;
      end
   end

   assign bcd = bcd_q;
   assign tc  = tc_q;

`ifdef BCD_COUNTER_N_SEG_EN
   for (genvar i = 0; i < DIGITS; i++) begin : g_seg
      bcd_to_7seg u_seg (
         .digit (bcd_q[4*i +: 4]),
         .seg   (seg[7*i +: 7])
      );
   end
`else
   assign seg = '1;
`endif

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n (DIGITS=2) against an integer reference model.
module tb_bcd_counter_n;

   logic        clk = 1'b0;
   logic        reset, en, up, load;
   logic [7:0]  load_val, limit;
   logic [7:0]  bcd;
   logic        tc;
   logic [13:0] seg;

   int nchk = 0;
   int nerr = 0;

   // Reference model state: plain decimal value and pulse flag.
   int m_val = 0;
   bit m_tc  = 1'b0;

   bcd_counter_n #(.DIGITS(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .bcd      (bcd),
      .tc       (tc),
      .seg      (seg)
   );

   always #5 clk = ~clk;

   // Decimal value of a 2-digit BCD byte; bad digits map to 9 (limit) or 0 (load).
   function automatic int dec_of(input logic [7:0] v, input bit is_limit);
      int hi, lo;
      hi = int'(v[7:4]);
      lo = int'(v[3:0]);
      if (hi > 9) hi = is_limit ? 9 : 0;
      if (lo > 9) lo = is_limit ? 9 : 0;
      return hi * 10 + lo;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [13:0] exp_seg(input int v);
`ifdef BCD_COUNTER_N_SEG_EN
      return {pat((v / 10) % 10), pat(v % 10)};
`else
      return 14'h3FFF + 14'(v * 0);
`endif
   endfunction

   // Drive one cycle of inputs, clock it, and advance the model.
   task automatic cyc(input bit r, input bit l, input bit e, input bit u,
                      input logic [7:0] lv, input logic [7:0] lim);
      int lv_i;
      @(negedge clk);
      reset = r; load = l; en = e; up = u; load_val = lv; limit = lim;
      @(posedge clk);
      #1;
      lv_i = dec_of(lim, 1'b1);
      if (r) begin
         m_val = 0; m_tc = 1'b0;
      end else if (l) begin
         m_val = dec_of(lv, 1'b0); m_tc = 1'b0;
      end else if (e) begin
         if (u) begin
            if (m_val >= lv_i) begin m_val = 0; m_tc = 1'b1; end
            else begin m_val = m_val + 1; m_tc = 1'b0; end
         end else begin
            if (m_val == 0) begin m_val = lv_i; m_tc = 1'b1; end
            else begin m_val = m_val - 1; m_tc = 1'b0; end
         end
      end else begin
         m_tc = 1'b0;
      end
   endtask

   task automatic test_reset();
      cyc(1, 0, 1, 1, 8'h55, 8'h99);
      nchk++;
      if (bcd !== 8'h00) begin
         nerr++; $display("FAIL reset_bcd: got %h want 00", bcd);
      end
      nchk++;
      if (tc !== 1'b0) begin
         nerr++; $display("FAIL reset_tc: got %b want 0", tc);
      end
      nchk++;
      if (seg !== exp_seg(0)) begin
         nerr++; $display("FAIL reset_seg: got %h want %h", seg, exp_seg(0));
      end
   endtask

   task automatic test_up_wrap();
      int tc_count = 0;
      for (int i = 0; i < 61; i++) begin
         cyc(0, 0, 1, 1, 8'h00, 8'h59);
         if (tc === 1'b1) tc_count++;
         nchk++;
         if (bcd !== to_bcd(m_val) || tc !== m_tc) begin
            nerr++;
            $display("FAIL up_step%0d: got %h/%b want %h/%b", i, bcd, tc, to_bcd(m_val), m_tc);
         end
         if (i == 59) begin
            nchk++;
            if (bcd !== 8'h00 || tc !== 1'b1) begin
               nerr++; $display("FAIL up_wrap: got %h/%b want 00/1", bcd, tc);
            end
         end
      end
      nchk++;
      if (tc_count != 1) begin
         nerr++; $display("FAIL up_tc_count: got %0d want 1", tc_count);
      end
   endtask

   task automatic test_down_wrap();
      logic [7:0] want [4] = '{8'h23, 8'h22, 8'h21, 8'h20};
      cyc(0, 1, 0, 0, 8'h00, 8'h23);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0, 8'h00, 8'h23);
         nchk++;
         if (bcd !== want[i] || tc !== (i == 0)) begin
            nerr++;
            $display("FAIL down_step%0d: got %h/%b want %h/%b", i, bcd, tc, want[i], i == 0);
         end
      end
   endtask

   task automatic test_load();
      cyc(0, 1, 1, 1, 8'h3C, 8'h99);
      nchk++;
      if (bcd !== 8'h30 || tc !== 1'b0) begin
         nerr++; $display("FAIL load_sanitize: got %h/%b want 30/0", bcd, tc);
      end
   endtask

   task automatic test_limit_lower();
      cyc(0, 1, 0, 1, 8'h45, 8'h99);
      cyc(0, 0, 1, 1, 8'h00, 8'h20);
      nchk++;
      if (bcd !== 8'h00 || tc !== 1'b1) begin
         nerr++; $display("FAIL limit_lower: got %h/%b want 00/1", bcd, tc);
      end
      // Limit 0: every step wraps and asserts tc.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, i[0], 8'h00, 8'h00);
         nchk++;
         if (bcd !== 8'h00 || tc !== 1'b1) begin
            nerr++; $display("FAIL limit_zero%0d: got %h/%b want 00/1", i, bcd, tc);
         end
      end
   endtask

   task automatic test_reset_mid();
      cyc(0, 1, 0, 1, 8'h37, 8'h99);
      cyc(1, 1, 1, 0, 8'h11, 8'h99);
      nchk++;
      if (bcd !== 8'h00 || tc !== 1'b0) begin
         nerr++; $display("FAIL reset_mid: got %h/%b want 00/0", bcd, tc);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 1, 8'h00, 8'h99);
         nchk++;
         if (bcd !== 8'h00 || tc !== 1'b0) begin
            nerr++; $display("FAIL hold%0d: got %h/%b want 00/0", i, bcd, tc);
         end
      end
   endtask

   task automatic test_seg();
      logic [13:0] want;
`ifdef BCD_COUNTER_N_SEG_EN
      want = 14'h0079;
`else
      want = 14'h3FFF;
`endif
      cyc(0, 1, 0, 1, 8'h81, 8'h99);
      nchk++;
      if (seg !== want) begin
         nerr++; $display("FAIL seg_81: got %h want %h", seg, want);
      end
   endtask

   task automatic test_random();
      bit r, l, e, u;
      logic [7:0] lv, lim;
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 49) == 0);
         l   = ($urandom_range(0, 9) == 0);
         e   = ($urandom_range(0, 3) != 0);
         u   = $urandom_range(0, 1) == 1;
         lv  = 8'($urandom_range(0, 255));
         lim = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : to_bcd($urandom_range(0, 99));
         cyc(r, l, e, u, lv, lim);
         nchk++;
         if (bcd !== to_bcd(m_val) || tc !== m_tc || seg !== exp_seg(m_val)) begin
            nerr++;
            $display("FAIL rand%0d: got %h/%b/%h want %h/%b/%h", i, bcd, tc, seg,
                     to_bcd(m_val), m_tc, exp_seg(m_val));
         end
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; limit = '0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load();
      test_limit_lower();
      test_reset_mid();
      test_seg();
      test_random();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
